// File: rtl/start_done_responder_if.sv
// start_done_responder_if: start/done/valid/ready bundle between initiator (master) and responder (slave).
// drop_cnt exists only when RESP_DROP_CNT_EN is defined.
interface start_done_responder_if #(parameter int DATA_W = 8);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic              busy;
  logic              done;
  logic              valid;
  logic [DATA_W-1:0] dout;
  logic              drop;
`ifdef RESP_DROP_CNT_EN
  logic [7:0]        drop_cnt;
  modport master (output start, din, ready, input busy, done, valid, dout, drop, drop_cnt);
  modport slave  (input start, din, ready, output busy, done, valid, dout, drop, drop_cnt);
`else
  modport master (output start, din, ready, input busy, done, valid, dout, drop);
  modport slave  (input start, din, ready, output busy, done, valid, dout, drop);
`endif
endinterface

// File: rtl/start_done_responder.sv
// start_done_responder: fixed-latency (LAT) responder returning din+1, dropping starts while occupied.
// Optional saturating drop counter enabled by RESP_DROP_CNT_EN.
module start_done_responder #(
  parameter int LAT    = 2,
  parameter int DATA_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  start_done_responder_if.slave  s
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT} state_t;
  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] data, data_nx, dout_r, dout_nx;
  logic              done_r, done_nx, valid_r, valid_nx, drop_r, drop_nx;
  logic              xfer, accept, fin;
  assign xfer   = state == WAIT && s.ready;
  assign accept = s.start && (state == IDLE || xfer);
  // completion happens on the last BUSY edge, or on the accept edge itself when LAT is 1
  assign fin    = (state == BUSY && cnt == 4'd1) || (accept && LAT == 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      data    <= '0;
      dout_r  <= '0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      data    <= data_nx;
      dout_r  <= dout_nx;
      done_r  <= done_nx;
      valid_r <= valid_nx;
      drop_r  <= drop_nx;
    end
  end
  always_comb begin
    state_nx = accept ? (LAT == 1 ? WAIT : BUSY) : fin ? WAIT : xfer ? IDLE : state;
    cnt_nx   = accept ? 4'(LAT - 1) : state == BUSY ? cnt - 4'd1 : cnt;
    data_nx  = accept ? s.din : data;
  end
  always_comb begin
    done_nx  = fin;
    valid_nx = fin || (valid_r && !xfer);
    dout_nx  = fin ? (accept ? s.din : data) + DATA_W'(1) : dout_r;
    drop_nx  = s.start && !accept;
  end
  assign s.busy  = state != IDLE;
  assign s.done  = done_r;
  assign s.valid = valid_r;
  assign s.dout  = dout_r;
  assign s.drop  = drop_r;
`ifdef RESP_DROP_CNT_EN
  logic [7:0] dcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= '0;
    else if (drop_r && dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
  end
  assign s.drop_cnt = dcnt;
`endif
endmodule
